// File: rtl/timer_period_counter_if.sv
// rtl/timer_period_counter_if.sv - control/config/status bundle between timer control block and period counter.
interface timer_period_counter_if #(
  parameter int NUM_BITS = 16
);
  logic [NUM_BITS-1:0] cfg_start_i;
  logic [NUM_BITS-1:0] cfg_end_i;
  logic [1:0]          cfg_mode_i;
  logic                ctrl_active_i;
  logic                ctrl_rst_i;
  logic                ctrl_cnt_upd_i;
  logic                ctrl_all_upd_i;
  logic                tick_i;
  logic [NUM_BITS-1:0] counter_o;
  logic                dir_o;
  logic                end_o;
  logic                cnt_update_o;
  logic                done_o;

  modport master (
    output cfg_start_i, cfg_end_i, cfg_mode_i,
    output ctrl_active_i, ctrl_rst_i, ctrl_cnt_upd_i, ctrl_all_upd_i, tick_i,
    input  counter_o, dir_o, end_o, cnt_update_o, done_o
  );

  modport slave (
    input  cfg_start_i, cfg_end_i, cfg_mode_i,
    input  ctrl_active_i, ctrl_rst_i, ctrl_cnt_upd_i, ctrl_all_upd_i, tick_i,
    output counter_o, dir_o, end_o, cnt_update_o, done_o
  );
endinterface

// File: rtl/timer_period_counter.sv
// rtl/timer_period_counter.sv - shadowed start/end/mode period counter with end/update pulses.
// Optional mode 11 down-wrap enabled by TIMER_CNT_DOWN_EN (otherwise mode 11 = up-wrap).
module timer_period_counter #(
  parameter int NUM_BITS = 16
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  timer_period_counter_if.slave bus
);

`ifdef TIMER_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  localparam logic [1:0] MODE_UP_DOWN  = 2'b01;
  localparam logic [1:0] MODE_ONE_SHOT = 2'b10;
  localparam logic [1:0] MODE_DOWN     = 2'b11;
  localparam logic [NUM_BITS-1:0] ONE  = NUM_BITS'(1);

  logic [NUM_BITS-1:0] shd_start_q, shd_start_d, shd_end_q, shd_end_d;
  logic [NUM_BITS-1:0] act_start_q, act_start_d, act_end_q, act_end_d;
  logic [1:0]          shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;
  logic                pending_q, pending_d;
  logic [NUM_BITS-1:0] counter_q, counter_d;
  logic                dir_q, dir_d, done_q, done_d;
  logic                end_q, end_d, upd_q, upd_d;
  logic                load_direct, load_shadow, step;
  logic                down_cur, down_new;

  assign load_direct = bus.ctrl_cnt_upd_i & bus.ctrl_all_upd_i;
  assign load_shadow = bus.ctrl_all_upd_i & pending_q & ~bus.ctrl_cnt_upd_i;
  assign step        = bus.tick_i & bus.ctrl_active_i & ~bus.ctrl_rst_i & ~done_q;
  assign down_cur    = DOWN_EN && (act_mode_q == MODE_DOWN);
  assign down_new    = DOWN_EN && (act_mode_d == MODE_DOWN);

  always_comb begin
    shd_start_d = shd_start_q;
    shd_end_d   = shd_end_q;
    shd_mode_d  = shd_mode_q;
    pending_d   = pending_q;
    act_start_d = act_start_q;
    act_end_d   = act_end_q;
    act_mode_d  = act_mode_q;
    counter_d   = counter_q;
    dir_d       = dir_q;
    done_d      = done_q;
    end_d       = 1'b0;
    upd_d       = 1'b0;

    if (bus.ctrl_cnt_upd_i) begin
      shd_start_d = bus.cfg_start_i;
      shd_end_d   = bus.cfg_end_i;
      shd_mode_d  = bus.cfg_mode_i;
      pending_d   = ~bus.ctrl_all_upd_i;
    end
    if (load_direct) begin
      act_start_d = bus.cfg_start_i;
      act_end_d   = bus.cfg_end_i;
      act_mode_d  = bus.cfg_mode_i;
    end else if (load_shadow) begin
      act_start_d = shd_start_q;
      act_end_d   = shd_end_q;
      act_mode_d  = shd_mode_q;
      pending_d   = 1'b0;
    end

    // Reload sees this cycle's freshly loaded values; stepping compares against the running period.
    if (bus.ctrl_rst_i) begin
      counter_d = down_new ? act_end_d : act_start_d;
      dir_d     = 1'b0;
      done_d    = 1'b0;
    end else if (step) begin
      if (down_cur) begin
        if (counter_q == act_start_q) begin
          counter_d = act_end_q;
          end_d     = 1'b1;
          upd_d     = 1'b1;
        end else begin
          counter_d = counter_q - ONE;
        end
      end else if (act_mode_q == MODE_UP_DOWN) begin
        if (act_start_q == act_end_q && counter_q == act_end_q) begin
          end_d = 1'b1;
          upd_d = 1'b1;
        end else if (!dir_q) begin
          if (counter_q == act_end_q) begin
            dir_d     = 1'b1;
            counter_d = counter_q - ONE;
            end_d     = 1'b1;
          end else begin
            counter_d = counter_q + ONE;
          end
        end else begin
          if (counter_q == act_start_q) begin
            dir_d     = 1'b0;
            counter_d = counter_q + ONE;
            upd_d     = 1'b1;
          end else begin
            counter_d = counter_q - ONE;
          end
        end
      end else if (act_mode_q == MODE_ONE_SHOT) begin
        if (counter_q == act_end_q) begin
          done_d = 1'b1;
          end_d  = 1'b1;
          upd_d  = 1'b1;
        end else begin
          counter_d = counter_q + ONE;
        end
      end else begin
        if (counter_q == act_end_q) begin
          counter_d = act_start_q;
          end_d     = 1'b1;
          upd_d     = 1'b1;
        end else begin
          counter_d = counter_q + ONE;
        end
      end
    end

    // Only up-down keeps a direction bit across a mode load.
    if ((load_direct || load_shadow) && act_mode_d != MODE_UP_DOWN) begin
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shd_start_q <= '0;
      shd_end_q   <= '0;
      shd_mode_q  <= 2'b00;
      pending_q   <= 1'b0;
      act_start_q <= '0;
      act_end_q   <= '0;
      act_mode_q  <= 2'b00;
      counter_q   <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      end_q       <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      shd_start_q <= shd_start_d;
      shd_end_q   <= shd_end_d;
      shd_mode_q  <= shd_mode_d;
      pending_q   <= pending_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_mode_q  <= act_mode_d;
      counter_q   <= counter_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      end_q       <= end_d;
      upd_q       <= upd_d;
    end
  end

  assign bus.counter_o    = counter_q;
  assign bus.dir_o        = down_cur | dir_q;
  assign bus.end_o        = end_q;
  assign bus.cnt_update_o = upd_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_timer_period_counter.sv
// tb/tb_timer_period_counter.sv - directed plus randomized checks of timer_period_counter against a reference model.
module tb_timer_period_counter;
  localparam int N = 4;
  localparam int M = 1 << N;
`ifdef TIMER_CNT_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  timer_period_counter_if #(.NUM_BITS(N)) bus ();
  timer_period_counter #(.NUM_BITS(N)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt, m_dir, m_end, m_upd, m_done;
  int sh_start, sh_end, sh_mode, pend;
  int a_start, a_end, a_mode;

  function automatic bit mdown(int m);
    return DOWN && (m == 3);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dir = 0; m_end = 0; m_upd = 0; m_done = 0;
    sh_start = 0; sh_end = 0; sh_mode = 0; pend = 0;
    a_start = 0; a_end = 0; a_mode = 0;
  endtask

  task automatic model_step();
    int ns, ne, nm;
    bit load, e_end, e_upd;
    ns = a_start; ne = a_end; nm = a_mode; load = 0; e_end = 0; e_upd = 0;
    if (bus.ctrl_cnt_upd_i && bus.ctrl_all_upd_i) begin
      ns = int'(bus.cfg_start_i); ne = int'(bus.cfg_end_i); nm = int'(bus.cfg_mode_i);
      sh_start = ns; sh_end = ne; sh_mode = nm; pend = 0; load = 1;
    end else begin
      if (bus.ctrl_all_upd_i && pend != 0) begin
        ns = sh_start; ne = sh_end; nm = sh_mode; pend = 0; load = 1;
      end
      if (bus.ctrl_cnt_upd_i) begin
        sh_start = int'(bus.cfg_start_i); sh_end = int'(bus.cfg_end_i); sh_mode = int'(bus.cfg_mode_i);
        pend = 1;
      end
    end
    if (bus.ctrl_rst_i) begin
      m_cnt = mdown(nm) ? ne : ns; m_dir = 0; m_done = 0;
    end else if (bus.tick_i && bus.ctrl_active_i && m_done == 0) begin
      if (mdown(a_mode)) begin
        if (m_cnt == a_start) begin m_cnt = a_end; e_end = 1; e_upd = 1; end
        else m_cnt = (m_cnt + M - 1) % M;
      end else if (a_mode == 1) begin
        if (a_start == a_end && m_cnt == a_end) begin e_end = 1; e_upd = 1; end
        else if (m_dir == 0 && m_cnt == a_end) begin m_dir = 1; m_cnt = (m_cnt + M - 1) % M; e_end = 1; end
        else if (m_dir == 1 && m_cnt == a_start) begin m_dir = 0; m_cnt = (m_cnt + 1) % M; e_upd = 1; end
        else m_cnt = (m_dir == 0) ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
      end else if (a_mode == 2) begin
        if (m_cnt == a_end) begin m_done = 1; e_end = 1; e_upd = 1; end
        else m_cnt = (m_cnt + 1) % M;
      end else begin
        if (m_cnt == a_end) begin m_cnt = a_start; e_end = 1; e_upd = 1; end
        else m_cnt = (m_cnt + 1) % M;
      end
    end
    if (load && nm != 1) m_dir = 0;
    a_start = ns; a_end = ne; a_mode = nm;
    m_end = e_end; m_upd = e_upd;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".counter"}, 32'(bus.counter_o), 32'(m_cnt));
    check({tag, ".dir"}, 32'(bus.dir_o), mdown(a_mode) ? 32'd1 : 32'(m_dir));
    check({tag, ".end"}, 32'(bus.end_o), 32'(m_end));
    check({tag, ".upd"}, 32'(bus.cnt_update_o), 32'(m_upd));
    check({tag, ".done"}, 32'(bus.done_o), 32'(m_done));
  endtask

  task automatic drive(bit cu, bit au, bit rs, bit act, bit tk, int s, int e, int md);
    bus.ctrl_cnt_upd_i = cu;
    bus.ctrl_all_upd_i = au;
    bus.ctrl_rst_i     = rs;
    bus.ctrl_active_i  = act;
    bus.tick_i         = tk;
    bus.cfg_start_i    = N'(s);
    bus.cfg_end_i      = N'(e);
    bus.cfg_mode_i     = 2'(md);
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic load_start(int s, int e, int md);
    drive(1, 1, 1, 1, 1, s, e, md);
    cycle("load");
    drive(0, 0, 0, 1, 1, s, e, md);
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rstn = 1'b1;

    load_start(2, 5, 0);
    check("wrap.first", 32'(bus.counter_o), 32'd2);
    for (int i = 0; i < 4; i++) cycle("wrap");
    check("wrap.back_to_start", 32'(bus.counter_o), 32'd2);
    check("wrap.end_pulse", 32'(bus.end_o), 32'd1);

    load_start(0, 3, 1);
    for (int i = 0; i < 4; i++) cycle("updown");
    check("updown.turn_cnt", 32'(bus.counter_o), 32'd2);
    check("updown.turn_dir", 32'(bus.dir_o), 32'd1);
    check("updown.turn_end", 32'(bus.end_o), 32'd1);
    for (int i = 0; i < 3; i++) cycle("updown");
    check("updown.bottom_cnt", 32'(bus.counter_o), 32'd1);
    check("updown.bottom_dir", 32'(bus.dir_o), 32'd0);
    check("updown.bottom_upd", 32'(bus.cnt_update_o), 32'd1);

    load_start(0, 2, 2);
    for (int i = 0; i < 3; i++) cycle("oneshot");
    check("oneshot.hold", 32'(bus.counter_o), 32'd2);
    check("oneshot.done", 32'(bus.done_o), 32'd1);
    check("oneshot.pulse", 32'(bus.cnt_update_o), 32'd1);
    cycle("oneshot_idle");
    check("oneshot.single_pulse", 32'(bus.end_o), 32'd0);
    drive(0, 0, 1, 1, 1, 0, 2, 2);
    cycle("oneshot_rst");
    check("oneshot.rst_done", 32'(bus.done_o), 32'd0);

    load_start(0, 9, 0);
    for (int i = 0; i < 3; i++) cycle("shadow");
    drive(1, 0, 0, 1, 1, 0, 4, 0);
    cycle("shadow_cap");
    drive(0, 0, 0, 1, 1, 0, 4, 0);
    for (int i = 0; i < 5; i++) cycle("shadow");
    check("shadow.old_end", 32'(bus.counter_o), 32'd9);
    drive(0, 1, 0, 1, 1, 0, 4, 0);
    cycle("shadow_load");
    drive(0, 0, 0, 1, 1, 0, 4, 0);
    for (int i = 0; i < 5; i++) cycle("shadow_new");
    check("shadow.new_wrap", 32'(bus.counter_o), 32'd0);
    check("shadow.new_pulse", 32'(bus.end_o), 32'd1);

    for (int i = 0; i < 2; i++) cycle("pre_gate");
    drive(0, 0, 0, 0, 1, 0, 4, 0);
    for (int i = 0; i < 5; i++) cycle("gate");
    check("gate.hold", 32'(bus.counter_o), 32'd2);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rstn = 1'b1;

    load_start(1, 3, 3);
    check("mode3.load", 32'(bus.counter_o), DOWN ? 32'd3 : 32'd1);
    for (int i = 0; i < 3; i++) cycle("mode3");
    check("mode3.wrap", 32'(bus.counter_o), DOWN ? 32'd3 : 32'd1);
    check("mode3.pulse", 32'(bus.cnt_update_o), 32'd1);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)), int'($urandom_range(0, 3)));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_period_counter.md
Name: timer_period_counter

Overview:
- Counting engine driven by the timer control block's ctrl_* outputs.
- Returns the end-of-period event, cnt_update_o, which the control block consumes as its counter-update input.
- Holds shadowed start, end and mode values. Counts on qualified ticks from the prescaler/input stage.
- Drives counter value, end event and direction to the comparator stage.

Parameters:
- NUM_BITS, 16, width of counter, start and end values.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_start_i  in  NUM_BITS  programmed start value
- cfg_end_i  in  NUM_BITS  programmed end value
- cfg_mode_i  in  2  00 up-wrap, 01 up-down, 10 one-shot, 11 see Optional Feature
- ctrl_active_i  in  1  counting enabled
- ctrl_rst_i  in  1  reload counter from active start value
- ctrl_cnt_upd_i  in  1  capture cfg_* into shadow, set pending
- ctrl_all_upd_i  in  1  transfer shadow into active registers
- tick_i  in  1  count-enable strobe, one cycle per count
- counter_o  out  NUM_BITS  current count
- dir_o  out  1  0 = counting up, 1 = counting down
- end_o  out  1  one-cycle pulse, counter reached end value
- cnt_update_o  out  1  one-cycle pulse, period complete (to control block)
- done_o  out  1  one-shot finished, held until ctrl_rst_i

Behaviour:
- Reset values: counter_o=0, dir_o=0, end_o=0, cnt_update_o=0, done_o=0.
- Reset values, internal: shadow and active start/end = 0, mode = 00, pending = 0.
- Shadow: on ctrl_cnt_upd_i, shadow <= cfg_* and pending <= 1.
- Active registers: on ctrl_all_upd_i with pending=1, active <= shadow and pending <= 0.
- ctrl_all_upd_i with pending=0 is ignored.
- Bypass: ctrl_cnt_upd_i and ctrl_all_upd_i in the same cycle (start sequence) load active directly from cfg_*; pending ends at 0.
- ctrl_rst_i: counter <= start value that is active after this cycle's update (bypass value if loading). Also dir_o <= 0, done_o <= 0.
- ctrl_rst_i has priority over counting; no pulses are generated in a reset cycle.
- Count step: occurs when tick_i & ctrl_active_i & ~ctrl_rst_i & ~done_o. Ticks with ctrl_active_i=0 are dropped, not queued.
- Up-wrap: counter==end -> counter <= start, end_o and cnt_update_o pulse. Otherwise counter+1, modulo 2^NUM_BITS, so start>end wraps through 0.
- Up-down, dir 0: counter==end -> dir <= 1, counter-1, end_o pulse. Otherwise +1.
- Up-down, dir 1: counter==start -> dir <= 0, counter+1, cnt_update_o pulse. Otherwise -1.
- Up-down with start==end: counter holds; end_o and cnt_update_o both pulse every step.
- One-shot: counter==end -> counter holds, done_o <= 1, end_o and cnt_update_o pulse. Otherwise +1.
- Pulse timing: pulses are registered, high in the cycle after the qualifying step edge, one cycle wide. Consecutive steps give back-to-back pulses.
- Mode change: takes effect only via an active-register load. Switching to up-wrap while dir=1 forces dir <= 0 on the load cycle.
- Comparisons use active values only. A new shadow never affects the running period until ctrl_all_upd_i.

Optional Feature:
- Macro: TIMER_CNT_DOWN_EN.
- Defined: mode 11 = down-wrap. dir_o=1. counter==start -> counter <= end, end_o and cnt_update_o pulse; otherwise -1. ctrl_rst_i reloads the end value instead of start in this mode.
- Not defined: mode 11 behaves exactly as up-wrap; dir_o stays 0.

Test Plan:
- Start: start=2, end=5, mode 00; ctrl_cnt_upd+ctrl_all_upd+ctrl_rst in one cycle, active, tick every cycle -> counter 2,3,4,5,2; end_o/cnt_update_o pulse once per 4 ticks.
- Up-down: start=0, end=3, mode 01 -> counter 0,1,2,3,2,1,0,1; end_o after 3, cnt_update_o after 0; dir_o toggles at 3 and 0.
- One-shot: start=0, end=2, mode 10 -> counter 0,1,2 then holds; done_o=1; single end_o/cnt_update_o pulse; ctrl_rst_i -> counter 0, done_o=0.
- Shadow: running start=0, end=9; ctrl_cnt_upd with end=4 at count 3 -> continues to 9. ctrl_all_upd at the wrap loads end=4; next period wraps at 4.
- Gating: ctrl_active_i=0 with tick_i high for 5 cycles -> counter unchanged, no pulses. rstn_i low mid-count -> all outputs 0 immediately.
- TIMER_CNT_DOWN_EN: start=1, end=3, mode 11 -> counter 3,2,1,3, pulse at wrap. Without the macro, same stimulus gives up-wrap 1,2,3,1.
